data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Data-side memory responder for the OpenMIPS core, sitting at the RAM end of the MEM stage's `mem_ce`/`mem_we`/`mem_sel`/`mem_addr`/`mem_data` request port. It holds a big-endian, byte-lane-addressable word memory with a configurable access latency. It serves each load or store through a small wait-state FSM and raises `stallreq_o` to freeze the pipeline until load data is valid or the store has been committed.

## Interface
- `ADDR_WIDTH`, default 10: word-address bits; memory depth is 2^ADDR_WIDTH 32-bit words.
- `WAIT_CYCLES`, default 1: extra wait states per access, legal range 0..7.
- `clk`  in  1  single clock; all state is updated on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mem_ce_i`  in  1  request valid; held stable by the MEM stage while stalled.
- `mem_we_i`  in  1  1 selects store, 0 selects load.
- `mem_addr_i`  in  32  byte address; word index is `mem_addr_i[ADDR_WIDTH+1:2]`.
- `mem_sel_i`  in  4  byte-lane enables; `sel[3]` is byte offset 0 and maps to bits 31:24 (big-endian).
- `mem_data_i`  in  32  store data, already lane-replicated by the MEM stage.
- `mem_data_o`  out  32  load data; valid only in DONE.
- `stallreq_o`  out  1  pipeline stall request to the ctrl block.

## Operation
- FSM states and transitions:
  - IDLE: on `mem_ce_i`=1, capture addr/we/sel/data into request registers, load `cnt`=WAIT_CYCLES, go to BUSY.
  - BUSY: if `cnt`≠0, decrement `cnt`. If `cnt`=0, perform the access and go to DONE.
    - Load: latch the full word into `rdata_q`.
    - Store: write only lanes whose captured sel bit is 1.
  - DONE: unconditionally return to IDLE on the next edge.
- `stallreq_o` = `mem_ce_i` and state∈{IDLE,BUSY}. It is combinational and 0 in DONE.
- `mem_data_o` = `rdata_q` in DONE after a load; 32'h0 in every other case, including DONE after a store.
- Lane extraction and sign/zero extension stay in the MEM stage. This block always returns the whole word.
- Inputs are sampled only on the IDLE→BUSY edge. Changes to addr/we/sel/data during BUSY are ignored.
- Abort: `mem_ce_i`=0 while in BUSY (exception flush) returns the FSM to IDLE on the next edge. No array write occurs and `rdata_q` is unchanged.
- Address rules:
  - Bits above `ADDR_WIDTH+1` are ignored, so addresses alias modulo depth.
  - `addr[1:0]` is ignored; `sel` alone selects lanes.
- A store with `sel`=4'b0000 runs the full FSM and writes nothing.
- Back-to-back requests: a new request is recognised in IDLE, one cycle after DONE. There is no pipelining of requests.

## Timing
- Reset values:
  - state=IDLE, `cnt`=0, `rdata_q`=0, request registers=0.
  - Outputs: `mem_data_o`=0, `stallreq_o`=0 while `mem_ce_i`=0.
  - Memory array contents are not reset.
- Reset is asserted asynchronously and released synchronously to `clk` by the top level. Reset mid-access discards the access; any store not yet committed is not written.
- Stall length per access is WAIT_CYCLES+2 cycles: one in IDLE plus WAIT_CYCLES+1 in BUSY.
  - Load data appears in DONE and is captured by the MEM/WB register on the edge that leaves DONE.
  - A store commits on the BUSY→DONE edge.
- A load issued right after a store to the same word returns the new data, because the store commits before the next request is captured.

## Structure
- Shared package `data_mem_pkg`:
  - state encoding constants S_IDLE, S_BUSY, S_DONE (2 bits);
  - width constants: data width 32, sel width 4, counter width 3;
  - `ZeroWord`, consistent with the existing define file.
- Sub-module `data_ram_bank`: four 8-bit-wide synchronous arrays of depth 2^ADDR_WIDTH.
  - Ports: per-lane write enables, one shared word index, write data, registered read data.
- The FSM, counter and output muxing live in `data_mem_responder`.

## Test plan
- Reset: hold `rst_n`=0 with `mem_ce_i`=1. Required: `mem_data_o`=0 and state=IDLE. After release, `stallreq_o`=1 in the first cycle.
- SW then LW, WAIT_CYCLES=1:
  - Store 32'hDEADBEEF to 32'h0000_0010 with sel=1111 → `stallreq_o` high for exactly 3 cycles.
  - Load from 0x10 → `mem_data_o`=32'hDEADBEEF in DONE.
- SB lane check:
  - Word 0x20 preloaded with 32'h11223344.
  - SB at 0x21 with data 32'hAAAAAAAA, sel=0100 → a later load returns 32'h11AA3344.
- Abort:
  - Issue a store of 32'h55555555 to 0x30, drop `mem_ce_i` in BUSY → word unchanged, FSM in IDLE the next cycle.
  - Same with a load → `rdata_q` unchanged.
- Aliasing and zero-sel, ADDR_WIDTH=10:
  - A store to 32'h0000_1004 is readable at 0x4.
  - A store with sel=0000 leaves the word intact and still stalls WAIT_CYCLES+2 cycles.
- WAIT_CYCLES=0 and 7: measured stall length is 2 and 9 cycles respectively, with no gap other than one IDLE cycle between back-to-back loads.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data-side memory responder.
package data_mem_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned SEL_W  = 4;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned LANE_W = DATA_W / SEL_W;

    localparam logic [DATA_W-1:0] ZeroWord = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Request fields captured on the IDLE->BUSY edge (word index held separately).
    typedef struct packed {
        logic              we;
        logic [SEL_W-1:0]  sel;
        logic [DATA_W-1:0] data;
    } mem_req_t;

endpackage

// File: rtl/data_mem_responder_if.sv
// MEM-stage data request port: master is the pipeline, slave is the RAM responder.
interface data_mem_responder_if;
    import data_mem_pkg::*;

    logic              mem_ce_i;
    logic              mem_we_i;
    logic [31:0]       mem_addr_i;
    logic [SEL_W-1:0]  mem_sel_i;
    logic [DATA_W-1:0] mem_data_i;
    logic [DATA_W-1:0] mem_data_o;
    logic              stallreq_o;

    modport master (
        output mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i,
        input  mem_data_o, stallreq_o
    );

    modport slave (
        input  mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i,
        output mem_data_o, stallreq_o
    );
endinterface

// File: rtl/data_ram_bank.sv
// Four byte-wide synchronous arrays sharing one word index; lane 3 holds bits 31:24.
module data_ram_bank
    import data_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [SEL_W-1:0]      we_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] idx_i,
    input  logic [DATA_W-1:0]     wdata_i,
    output logic [DATA_W-1:0]     rdata_o
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [SEL_W-1:0][LANE_W-1:0] rd_word_c;
    logic [DATA_W-1:0]            rdata_d;
    logic [DATA_W-1:0]            rdata_q;

    for (genvar l = 0; l < SEL_W; l++) begin : g_lane
        logic [LANE_W-1:0] mem [DEPTH];

        always_ff @(posedge clk) begin
            if (we_i[l]) begin
                mem[idx_i] <= wdata_i[l*LANE_W +: LANE_W];
            end
        end

        assign rd_word_c[l] = mem[idx_i];
    end

    // Read register only updates on an enabled read, so aborts leave it intact.
    always_comb begin
        rdata_d = rdata_q;
        if (re_i) begin
            rdata_d = rd_word_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= ZeroWord;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Wait-state memory responder for the MEM stage: one request at a time,
// stalls the pipeline until the load word is valid or the store has committed.
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    data_mem_responder_if.slave  bus
);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    mem_req_t              req_q, req_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;

    logic [SEL_W-1:0]      ram_we_c;
    logic                  ram_re_c;
    logic [DATA_W-1:0]     ram_rdata;

    // Address bits outside the word index are intentionally ignored (aliasing).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.mem_addr_i[31:ADDR_WIDTH+2], bus.mem_addr_i[1:0]};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        req_d    = req_q;
        idx_d    = idx_q;
        ram_we_c = '0;
        ram_re_c = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.mem_ce_i) begin
                    req_d.we   = bus.mem_we_i;
                    req_d.sel  = bus.mem_sel_i;
                    req_d.data = bus.mem_data_i;
                    idx_d      = bus.mem_addr_i[ADDR_WIDTH+1:2];
                    cnt_d      = CNT_W'(WAIT_CYCLES);
                    state_d    = S_BUSY;
                end
            end
            S_BUSY: begin
                if (!bus.mem_ce_i) begin
                    state_d = S_IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = S_DONE;
                    if (req_q.we) begin
                        ram_we_c = req_q.sel;
                    end else begin
                        ram_re_c = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            idx_q   <= idx_d;
        end
    end

    data_ram_bank #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (ram_we_c),
        .re_i    (ram_re_c),
        .idx_i   (idx_q),
        .wdata_i (req_q.data),
        .rdata_o (ram_rdata)
    );

    assign bus.stallreq_o = bus.mem_ce_i && (state_q != S_DONE);
    assign bus.mem_data_o = (state_q == S_DONE && !req_q.we) ? ram_rdata : ZeroWord;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder at WAIT_CYCLES = 1, 0 and 7.
module tb_data_mem_responder;
    import data_mem_pkg::*;

    logic clk;
    logic rst_n;

    logic        ce    [3];
    logic        we    [3];
    logic [31:0] addr  [3];
    logic [3:0]  sel   [3];
    logic [31:0] wdata [3];
    logic [31:0] rdata [3];
    logic        stall [3];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    data_mem_responder_if bus_w1 ();
    data_mem_responder_if bus_w0 ();
    data_mem_responder_if bus_w7 ();

    assign bus_w1.mem_ce_i   = ce[0];
    assign bus_w1.mem_we_i   = we[0];
    assign bus_w1.mem_addr_i = addr[0];
    assign bus_w1.mem_sel_i  = sel[0];
    assign bus_w1.mem_data_i = wdata[0];
    assign rdata[0]          = bus_w1.mem_data_o;
    assign stall[0]          = bus_w1.stallreq_o;

    assign bus_w0.mem_ce_i   = ce[1];
    assign bus_w0.mem_we_i   = we[1];
    assign bus_w0.mem_addr_i = addr[1];
    assign bus_w0.mem_sel_i  = sel[1];
    assign bus_w0.mem_data_i = wdata[1];
    assign rdata[1]          = bus_w0.mem_data_o;
    assign stall[1]          = bus_w0.stallreq_o;

    assign bus_w7.mem_ce_i   = ce[2];
    assign bus_w7.mem_we_i   = we[2];
    assign bus_w7.mem_addr_i = addr[2];
    assign bus_w7.mem_sel_i  = sel[2];
    assign bus_w7.mem_data_i = wdata[2];
    assign rdata[2]          = bus_w7.mem_data_o;
    assign stall[2]          = bus_w7.stallreq_o;

    data_mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(1)) u_dut_w1 (.clk(clk), .rst_n(rst_n), .bus(bus_w1));
    data_mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) u_dut_w0 (.clk(clk), .rst_n(rst_n), .bus(bus_w0));
    data_mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(7)) u_dut_w7 (.clk(clk), .rst_n(rst_n), .bus(bus_w7));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Entered and left on a falling edge with the DUT in IDLE.
    task automatic access(input int d, input logic we_v, input logic [31:0] a, input logic [3:0] s,
                          input logic [31:0] wd, input bit keep_ce,
                          output int stalls, output logic [31:0] rd, output int start_cyc);
        bit done;
        stalls    = 0;
        rd        = '0;
        done      = 1'b0;
        start_cyc = cyc;
        we[d]     = we_v;
        addr[d]   = a;
        sel[d]    = s;
        wdata[d]  = wd;
        ce[d]     = 1'b1;
        #1;
        for (int i = 0; i < 20; i++) begin
            if (stall[d]) begin
                stalls++;
                @(negedge clk);
                #1;
            end else begin
                rd   = rdata[d];
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL access_timeout: dut %0d still stalling after 20 cycles", d);
        end
        if (!keep_ce) ce[d] = 1'b0;
        @(negedge clk);
    endtask

    // Issue a request then drop mem_ce_i after one BUSY cycle.
    task automatic abort_access(input int d, input logic we_v, input logic [31:0] a, input logic [31:0] wd);
        we[d]    = we_v;
        addr[d]  = a;
        sel[d]   = 4'b1111;
        wdata[d] = wd;
        ce[d]    = 1'b1;
        @(negedge clk);
        ce[d]    = 1'b0;
        @(negedge clk);
        #1;
    endtask

    int          st;
    int          t0;
    int          t1;
    logic [31:0] rd;

    initial begin
        for (int i = 0; i < 3; i++) begin
            ce[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; sel[i] = '0; wdata[i] = '0;
        end
        rst_n = 1'b0;
        ce[0] = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_data_o", rdata[0], 32'h0);
        check_eq("rst_state",  32'(u_dut_w1.state_q), 32'(S_IDLE));
        check_eq("rst_stall",  32'(stall[0]), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("post_rst_stall", 32'(stall[0]), 32'd1);
        ce[0] = 1'b0;
        @(negedge clk);

        // Word store then load back, WAIT_CYCLES = 1
        access(0, 1'b1, 32'h0000_0010, 4'b1111, 32'hDEAD_BEEF, 1'b0, st, rd, t0);
        check_eq("sw_stall", 32'(st), 32'd3);
        check_eq("sw_done_data_zero", rd, 32'h0);
        access(0, 1'b0, 32'h0000_0010, 4'b1111, 32'h0, 1'b0, st, rd, t0);
        check_eq("lw_stall", 32'(st), 32'd3);
        check_eq("lw_data", rd, 32'hDEAD_BEEF);

        // Single byte store into offset 1 (bits 23:16)
        access(0, 1'b1, 32'h0000_0020, 4'b1111, 32'h1122_3344, 1'b0, st, rd, t0);
        access(0, 1'b1, 32'h0000_0021, 4'b0100, 32'hAAAA_AAAA, 1'b0, st, rd, t0);
        access(0, 1'b0, 32'h0000_0020, 4'b1111, 32'h0, 1'b0, st, rd, t0);
        check_eq("sb_lane", rd, 32'h11AA_3344);

        // Aborted store must not write
        access(0, 1'b1, 32'h0000_0030, 4'b1111, 32'hCAFE_F00D, 1'b0, st, rd, t0);
        abort_access(0, 1'b1, 32'h0000_0030, 32'h5555_5555);
        check_eq("abort_st_state", 32'(u_dut_w1.state_q), 32'(S_IDLE));
        @(negedge clk);
        access(0, 1'b0, 32'h0000_0030, 4'b1111, 32'h0, 1'b0, st, rd, t0);
        check_eq("abort_st_word", rd, 32'hCAFE_F00D);

        // Aborted load must leave the read register untouched
        abort_access(0, 1'b0, 32'h0000_0010, 32'h0);
        check_eq("abort_ld_state", 32'(u_dut_w1.state_q), 32'(S_IDLE));
        check_eq("abort_ld_rdata_q", u_dut_w1.u_bank.rdata_q, 32'hCAFE_F00D);
        @(negedge clk);

        // Aliasing modulo 1K words, and a store with no lanes enabled
        access(0, 1'b1, 32'h0000_1004, 4'b1111, 32'h0BAD_C0DE, 1'b0, st, rd, t0);
        access(0, 1'b0, 32'h0000_0004, 4'b1111, 32'h0, 1'b0, st, rd, t0);
        check_eq("alias_word", rd, 32'h0BAD_C0DE);
        access(0, 1'b1, 32'h0000_0004, 4'b0000, 32'hFFFF_FFFF, 1'b0, st, rd, t0);
        check_eq("zero_sel_stall", 32'(st), 32'd3);
        access(0, 1'b0, 32'h0000_0004, 4'b1111, 32'h0, 1'b0, st, rd, t0);
        check_eq("zero_sel_word", rd, 32'h0BAD_C0DE);

        // WAIT_CYCLES = 0: back-to-back loads
        access(1, 1'b1, 32'h0000_0008, 4'b1111, 32'h1234_5678, 1'b0, st, rd, t0);
        check_eq("w0_sw_stall", 32'(st), 32'd2);
        access(1, 1'b0, 32'h0000_0008, 4'b1111, 32'h0, 1'b1, st, rd, t0);
        check_eq("w0_lw1_stall", 32'(st), 32'd2);
        check_eq("w0_lw1_data", rd, 32'h1234_5678);
        access(1, 1'b0, 32'h0000_0008, 4'b1111, 32'h0, 1'b0, st, rd, t1);
        check_eq("w0_lw2_stall", 32'(st), 32'd2);
        check_eq("w0_lw2_data", rd, 32'h1234_5678);
        check_eq("w0_b2b_period", 32'(t1 - t0), 32'd3);

        // WAIT_CYCLES = 7: back-to-back loads
        access(2, 1'b1, 32'h0000_000C, 4'b1111, 32'h8765_4321, 1'b0, st, rd, t0);
        check_eq("w7_sw_stall", 32'(st), 32'd9);
        access(2, 1'b0, 32'h0000_000C, 4'b1111, 32'h0, 1'b1, st, rd, t0);
        check_eq("w7_lw1_stall", 32'(st), 32'd9);
        check_eq("w7_lw1_data", rd, 32'h8765_4321);
        access(2, 1'b0, 32'h0000_000C, 4'b1111, 32'h0, 1'b0, st, rd, t1);
        check_eq("w7_lw2_stall", 32'(st), 32'd9);
        check_eq("w7_lw2_data", rd, 32'h8765_4321);
        check_eq("w7_b2b_period", 32'(t1 - t0), 32'd10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
